// File: rtl/cp0_except.sv
// cp0_except: MIPS CP0 register file with exception/interrupt encoding and EPC/Status/Cause update.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i      mtc0 write (8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC)
//   raddr_i, data_o             mfc0 read of registered (pre-write) value, unmapped reads 0
//   int_i                       external interrupt lines into Cause.IP[7:2]
//   exc_flags_i                 MEM-stage exception flags (bits 15:8)
//   inst_addr_i, in_delayslot_i, badaddr_i   MEM-stage PC, delay-slot flag, faulting address
//   excepttype_o                encoded exception for the pipeline controller
//   cp0_epc_o                   EPC including a same-cycle mtc0, for eret redirection
//   status_o, cause_o, epc_o, count_o, compare_o, timer_int_o   register views
module cp0_except #(
  parameter logic [31:0] STATUS_RST      = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR_NOTE = 32'hbfc0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] exc_flags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badaddr_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);
  logic [31:0] count, compare, status, cause, epc, badvaddr;
  logic        timer_int;
  logic [31:0] status_f, cause_f, epc_f;
  logic [7:0]  f;
  logic        wr_bad, wr_cnt, wr_cmp, wr_st, wr_ca, wr_epc;
  logic        int_pend, exc, eret, adr;
  logic        unused_ok;
  assign unused_ok = &{1'b0, exc_flags_i[31:16], exc_flags_i[7:0], EXC_VECTOR_NOTE};
  assign wr_bad = we_i && waddr_i == 5'd8;
  assign wr_cnt = we_i && waddr_i == 5'd9;
  assign wr_cmp = we_i && waddr_i == 5'd11;
  assign wr_st  = we_i && waddr_i == 5'd12;
  assign wr_ca  = we_i && waddr_i == 5'd13;
  assign wr_epc = we_i && waddr_i == 5'd14;
  // Same-cycle mtc0 is visible to interrupt decode and eret; only Cause.IP[1:0] is software-writable
  assign status_f = wr_st ? wdata_i : status;
  assign cause_f  = wr_ca ? {cause[31:10], wdata_i[9:8], cause[7:0]} : cause;
  assign epc_f    = wr_epc ? wdata_i : epc;
  assign f = exc_flags_i[15:8];
  assign int_pend = inst_addr_i != 32'd0 && status_f[0] && !status_f[1] &&
                    |(cause_f[15:8] & status_f[15:8]);
  always_comb
    excepttype_o = (rst || inst_addr_i == 32'd0) ? 32'h00 :
                   int_pend ? 32'h01 :
                   f[6]     ? 32'h0e :
                   f[7]     ? 32'h0f :
                   f[2]     ? 32'h0a :
                   f[1]     ? 32'h09 :
                   f[0]     ? 32'h08 :
                   f[4]     ? 32'h0c :
                   f[3]     ? 32'h0d :
                   f[5]     ? 32'h10 : 32'h00;
  assign eret = excepttype_o == 32'h10;
  assign exc  = excepttype_o != 32'h00 && !eret;
  assign adr  = excepttype_o == 32'h0e || excepttype_o == 32'h0f;
  always_ff @(posedge clk)
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      status    <= STATUS_RST;
      cause     <= '0;
      epc       <= '0;
      badvaddr  <= '0;
      timer_int <= 1'b0;
    end else begin
      count     <= wr_cnt ? wdata_i : count + 32'd1;
      compare   <= wr_cmp ? wdata_i : compare;
      timer_int <= wr_cmp ? 1'b0 : (compare != 32'd0 && count == compare) ? 1'b1 : timer_int;
      status    <= {status_f[31:2], exc | (status_f[1] & ~eret), status_f[0]};
      // A nested exception (EXL already set) keeps the original EPC and BD
      cause     <= {(exc && !status_f[1]) ? in_delayslot_i : cause_f[31], cause_f[30:16],
                    int_i[5] | timer_int, int_i[4:0], cause_f[9:7],
                    exc ? excepttype_o[4:0] : cause_f[6:2], cause_f[1:0]};
      epc       <= (exc && !status_f[1]) ? (in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i) : epc_f;
      badvaddr  <= adr ? badaddr_i : wr_bad ? wdata_i : badvaddr;
    end
  always_comb
    data_o = raddr_i == 5'd8  ? badvaddr :
             raddr_i == 5'd9  ? count :
             raddr_i == 5'd11 ? compare :
             raddr_i == 5'd12 ? status :
             raddr_i == 5'd13 ? cause :
             raddr_i == 5'd14 ? epc : 32'd0;
  assign cp0_epc_o   = epc_f;
  assign status_o    = status;
  assign cause_o     = cause;
  assign epc_o       = epc;
  assign count_o     = count;
  assign compare_o   = compare;
  assign timer_int_o = timer_int;
endmodule

// File: doc/cp0_except.md
CP0_EXCEPT -- requirements
Module: cp0_except

Interface
REQ-001 Parameter STATUS_RST, default 32'h0040_0000, Status reset value (BEV=1).
REQ-002 Parameter EXC_VECTOR_NOTE, default 32'hbfc0_0380, documentation only; this block never drives the vector.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 we_i / waddr_i / wdata_i  in  1/5/32  mtc0 write from WB; addresses 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
REQ-006 raddr_i  in  5  mfc0 read address; data_o  out  32  read data.
REQ-007 int_i  in  6  external hardware interrupt lines.
REQ-008 exc_flags_i  in  32  raw MEM-stage flags: bit8 syscall, 9 break, 10 reserved inst, 11 trap, 12 overflow, 13 eret, 14 AdEL, 15 AdES.
REQ-009 inst_addr_i / in_delayslot_i / badaddr_i  in  32/1/32  MEM-stage PC, delay-slot flag, faulting address.
REQ-010 excepttype_o  out  32  encoded exception to ctrl: 0x01 int, 0x08 syscall, 0x09 break, 0x0a RI, 0x0c Ov, 0x0d trap, 0x0e AdEL, 0x0f AdES, 0x10 eret, 0 none.
REQ-011 cp0_epc_o  out  32  forwarded EPC for eret target.
REQ-012 status_o, cause_o, epc_o, count_o, compare_o  out  32 each; timer_int_o  out  1.

Function
REQ-013 Forwarded view: Status, Cause, EPC used by decode logic and cp0_epc_o SHALL reflect a same-cycle we_i write to that address (Cause: only IP[1:0] writable).
REQ-014 Interrupt pending = inst_addr_i!=0 and Status.IE=1 and Status.EXL=0 and (Cause.IP[7:0] & Status.IM[7:0])!=0, using forwarded values.
REQ-015 excepttype_o SHALL be combinational, priority: int > AdEL > AdES > RI > break > syscall > Ov > trap > eret; 0 if inst_addr_i==0 or no flag.
REQ-016 Count SHALL increment by 1 every cycle, wrapping 32'hFFFF_FFFF to 0; an mtc0 to Count that cycle loads wdata_i instead of incrementing.
REQ-017 When Compare!=0 and Count==Compare, timer_int_o SHALL go 1 next cycle and hold until an mtc0 to Compare, which clears it next cycle.
REQ-018 Cause.IP[7:2] SHALL register int_i each cycle, with IP7 = int_i[5] OR timer_int_o.
REQ-019 On excepttype_o in {01,08,09,0a,0c,0d,0e,0f} at a clk edge: if Status.EXL=0, EPC <= in_delayslot_i ? inst_addr_i-4 : inst_addr_i and Cause.BD <= in_delayslot_i; if EXL already 1, EPC and BD unchanged; always Status.EXL<=1, Cause.ExcCode<=excepttype_o[4:0].
REQ-020 For 0x0e/0x0f, BadVAddr <= badaddr_i at the same edge.
REQ-021 On excepttype_o==0x10 at a clk edge: Status.EXL<=0; no other register changes.
REQ-022 Simultaneous mtc0 and exception: exception update wins for EXL, EPC, BD, ExcCode, BadVAddr; all other written fields take wdata_i.
REQ-023 data_o SHALL return the registered (pre-write) value of raddr_i; unmapped addresses read 0.
REQ-024 Writes to unmapped addresses SHALL be ignored.

Reset
REQ-025 With rst=1 at a clk edge: Count=0, Compare=0, Status=STATUS_RST, Cause=0, EPC=0, BadVAddr=0, timer_int_o=0.
REQ-026 rst SHALL override every same-cycle write, exception and count increment; excepttype_o is 0 during rst.

Verification
REQ-027 Reset, then exc_flags_i bit8, inst_addr_i=32'h8000_0100, delayslot=0 -> excepttype_o=0x08; next cycle EPC=32'h8000_0100, Status.EXL=1, Cause.ExcCode=8.
REQ-028 Delay slot: overflow bit12, inst_addr_i=32'h8000_0204, delayslot=1 -> excepttype_o=0x0c; EPC=32'h8000_0200, Cause.BD=1.
REQ-029 Timer: mtc0 Compare=5, Count=0 -> timer_int_o=1 one cycle after Count==5; with Status=32'h0000_8001 -> excepttype_o=0x01; mtc0 Compare clears it.
REQ-030 ERET with same-cycle mtc0 EPC=32'h8000_0400 -> excepttype_o=0x10, cp0_epc_o=32'h8000_0400; next cycle EXL=0.
REQ-031 Priority/nesting: flags bit14 and bit8 together with EXL=1 -> excepttype_o=0x0e, BadVAddr=badaddr_i, EPC unchanged.
REQ-032 Count wrap: mtc0 Count=32'hFFFF_FFFF -> next cycle 32'hFFFF_FFFF, following cycle 0.
